// File: rtl/ifu_param.sv
// Instruction fetch unit: direct-mapped I-cache, 2-bit BHT predictor,
// single-line refill FSM and an instruction queue feeding decode.
module ifu_param #(
  parameter int CACHE_LINES = 16,
  parameter int LINE_BYTES  = 64,
  parameter int BHT_ENTRIES = 256,
  parameter int IQ_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  input  logic                    bp_upd_valid,
  input  logic [31:0]             bp_upd_pc,
  input  logic                    bp_upd_taken,
  input  logic                    dec_ready,
  output logic                    inst_valid,
  output logic [31:0]             inst,
  output logic [31:0]             inst_pc,
  output logic                    inst_pred_taken,
  output logic                    mem_req_valid,
  output logic [31:0]             mem_req_addr,
  input  logic                    mem_resp_valid,
  input  logic [LINE_BYTES*8-1:0] mem_resp_data
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(CACHE_LINES);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WSL_W  = OFF_W - 2;
  localparam int BHT_W  = $clog2(BHT_ENTRIES);
  localparam int IQ_W   = $clog2(IQ_DEPTH);
  localparam int LINE_W = LINE_BYTES * 8;
  localparam logic [IQ_W:0] IQ_FULL = IQ_DEPTH[IQ_W:0];

  typedef enum logic {IDLE, MISS} state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } iq_t;

  logic [LINE_W-1:0]      data_q [CACHE_LINES];
  logic [TAG_W-1:0]       tag_q  [CACHE_LINES];
  logic [CACHE_LINES-1:0] vld_q;
  logic [1:0]             bht_q  [BHT_ENTRIES];
  iq_t                    iq_q   [IQ_DEPTH];

  logic [IQ_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IQ_W:0]   cnt_q, cnt_d;
  logic [31:0]     pc_q, pc_d;
  state_e          st_q, st_d;
  logic            req_v_q, req_v_d;
  logic [31:0]     req_a_q, req_a_d;

  logic [IDX_W-1:0]  idx, f_idx;
  logic [TAG_W-1:0]  tag, f_tag;
  logic [WSL_W-1:0]  wsel;
  logic [LINE_W-1:0] line;
  logic [31:0]       f_inst, j_imm, b_imm, npc;
  logic [1:0]        ctr;
  logic              hit, is_jal, is_br, pred;
  logic              full, push, pop, fill;
  logic [BHT_W-1:0]  upd_idx;

  assign idx    = pc_q[OFF_W +: IDX_W];
  assign tag    = pc_q[31 -: TAG_W];
  assign wsel   = pc_q[2 +: WSL_W];
  assign line   = data_q[idx];
  assign hit    = vld_q[idx] && (tag_q[idx] == tag);
  assign f_inst = line[32*wsel +: 32];

  assign is_jal = f_inst[6:0] == 7'b1101111;
  assign is_br  = f_inst[6:0] == 7'b1100011;
  assign j_imm  = {{12{f_inst[31]}}, f_inst[19:12], f_inst[20],
                   f_inst[30:21], 1'b0};
  assign b_imm  = {{20{f_inst[31]}}, f_inst[7], f_inst[30:25],
                   f_inst[11:8], 1'b0};
  assign ctr    = bht_q[pc_q[2 +: BHT_W]];

  always_comb begin
    pred = 1'b0;
    npc  = pc_q + 32'd4;
    unique case (1'b1)
      is_jal: begin
        pred = 1'b1;
        npc  = pc_q + j_imm;
      end
      is_br && ctr[1]: begin
        pred = 1'b1;
        npc  = pc_q + b_imm;
      end
      default: ;
    endcase
  end

  assign full       = cnt_q == IQ_FULL;
  assign inst_valid = cnt_q != '0;
  assign push       = rdy && !redirect_valid && hit && !full;
  assign pop        = rdy && !redirect_valid && inst_valid && dec_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    pc_d   = pc_q;
    if (rdy && redirect_valid) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      pc_d   = redirect_pc;
    end else if (rdy) begin
      if (push) begin
        tail_d = tail_q + 1'b1;
        pc_d   = npc;
      end
      if (pop) head_d = head_q + 1'b1;
      cnt_d = cnt_q + {{IQ_W{1'b0}}, push} - {{IQ_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      pc_q   <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) iq_q[tail_q] <= '{inst: f_inst, pc: pc_q, pred: pred};
  end

  assign inst            = iq_q[head_q].inst;
  assign inst_pc         = iq_q[head_q].pc;
  assign inst_pred_taken = iq_q[head_q].pred;

  assign upd_idx = bp_upd_pc[2 +: BHT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'd1;
    end else if (rdy && bp_upd_valid) begin
      if (bp_upd_taken && bht_q[upd_idx] != 2'd3)
        bht_q[upd_idx] <= bht_q[upd_idx] + 2'd1;
      else if (!bp_upd_taken && bht_q[upd_idx] != 2'd0)
        bht_q[upd_idx] <= bht_q[upd_idx] - 2'd1;
    end
  end

  // Refill always targets the latched request, even after a redirect
  assign fill  = !rst && rdy && (st_q == MISS) && mem_resp_valid;
  assign f_idx = req_a_q[OFF_W +: IDX_W];
  assign f_tag = req_a_q[31 -: TAG_W];

  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[f_idx] <= mem_resp_data;
      tag_q[f_idx]  <= f_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       vld_q        <= '0;
    else if (fill) vld_q[f_idx] <= 1'b1;
  end

  always_comb begin
    st_d    = st_q;
    req_v_d = req_v_q;
    req_a_d = req_a_q;
    if (rdy) begin
      unique case (st_q)
        IDLE: if (!hit) begin
          st_d    = MISS;
          req_v_d = 1'b1;
          req_a_d = {pc_q[31:OFF_W], {OFF_W{1'b0}}};
        end
        MISS: if (mem_resp_valid) begin
          st_d    = IDLE;
          req_v_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      req_v_q <= 1'b0;
      req_a_q <= '0;
    end else begin
      st_q    <= st_d;
      req_v_q <= req_v_d;
      req_a_q <= req_a_d;
    end
  end

  assign mem_req_valid = req_v_q;
  assign mem_req_addr  = req_a_q;

  logic unused;
  assign unused = ^{bp_upd_pc[31:BHT_W+2], bp_upd_pc[1:0]};
endmodule

// File: tb/tb_ifu_param.sv
// Scoreboard bench for ifu_param: a cycle-level reference of the fetch
// rules predicts queue contents and refill requests; a monitor compares.
module tb_ifu_param;
  localparam int CL  = 16;
  localparam int LB  = 64;
  localparam int BE  = 256;
  localparam int IQD = 4;

  logic clk = 1'b0;
  logic rst, rdy, dec_ready;
  logic redirect_valid, bp_upd_valid, bp_upd_taken;
  logic [31:0] redirect_pc, bp_upd_pc;
  logic inst_valid, inst_pred_taken, mem_req_valid;
  logic [31:0] inst, inst_pc, mem_req_addr;
  logic mem_resp_valid = 1'b0;
  logic [LB*8-1:0] mem_resp_data = '0;

  int passed = 0;
  int total  = 0;
  int img_mode = 0;

  always #5 clk = ~clk;

  ifu_param #(
    .CACHE_LINES(CL), .LINE_BYTES(LB), .BHT_ENTRIES(BE), .IQ_DEPTH(IQD)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bp_upd_valid(bp_upd_valid), .bp_upd_pc(bp_upd_pc),
    .bp_upd_taken(bp_upd_taken), .dec_ready(dec_ready),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_pred_taken(inst_pred_taken),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Program image: kind 0 NOP, 1 JAL, 2 B-type, 3 JALR; off = branch offset
  function automatic void info(input logic [31:0] a, output int k,
                               output int off);
    logic [31:0] h;
    k = 0;
    off = 0;
    if (img_mode == 1) begin
      if (a == 32'h8) begin k = 1; off = 256; end
      else if (a == 32'h10) begin k = 2; off = 64; end
    end else if (img_mode == 2) begin
      h = a * 32'h9E3779B1;
      h = h ^ (h >> 15);
      case (h[2:0])
        3'd0:       k = 1;
        3'd1, 3'd2: k = 2;
        3'd3:       k = 3;
        default:    k = 0;
      endcase
      off = (int'(h[10:4]) - 64) * 4;
      if (off == 0) off = 8;
    end
  endfunction

  function automatic logic [31:0] enc(input int k, input int off);
    logic [31:0] i;
    i = off;
    case (k)
      1:       enc = {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'h6F};
      2:       enc = {i[12], i[10:5], 10'd0, 3'd0, i[4:1], i[11], 7'h63};
      3:       enc = 32'h00008067;
      default: enc = 32'h00000013;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    int k, off;
    info(a, k, off);
    return enc(k, off);
  endfunction

  function automatic logic [LB*8-1:0] line_of(input logic [31:0] base);
    logic [LB*8-1:0] d;
    for (int w = 0; w < LB / 4; w++) d[32*w +: 32] = mem_word(base + 32'(4 * w));
    return d;
  endfunction

  // Reference state
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    bit          pred;
  } ent_t;
  ent_t expq[$];
  bit   popped = 0;
  bit   m_miss = 0;
  logic [31:0] m_pc = '0, m_req = '0;
  bit   mvld[CL];
  logic [31:0] mtag[CL];
  int   bht[BE];

  function automatic bit m_hit(input logic [31:0] a);
    int ix;
    ix = int'((a / LB) % CL);
    return mvld[ix] && (mtag[ix] == a / (LB * CL));
  endfunction

  logic [31:0] pc0, nxt;
  int   mk, moff, occ, ix;
  bit   mpred, mh;

  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      m_pc = '0;
      m_miss = 0;
      m_req = '0;
      foreach (mvld[i]) mvld[i] = 0;
      foreach (bht[i]) bht[i] = 1;
      expq.delete();
    end else if (rdy) begin
      pc0 = m_pc;
      occ = expq.size() + int'(popped);
      mh = m_hit(pc0);
      info(pc0, mk, moff);
      mpred = (mk == 1) || (mk == 2 && bht[int'((pc0 >> 2) % BE)] >= 2);
      nxt = mpred ? pc0 + moff : pc0 + 32'd4;
      if (bp_upd_valid) begin
        ix = int'((bp_upd_pc >> 2) % BE);
        if (bp_upd_taken) bht[ix] = (bht[ix] == 3) ? 3 : bht[ix] + 1;
        else bht[ix] = (bht[ix] == 0) ? 0 : bht[ix] - 1;
      end
      if (redirect_valid) begin
        expq.delete();
        m_pc = redirect_pc;
      end else if (mh && occ < IQD) begin
        expq.push_back('{mem_word(pc0), pc0, mpred});
        m_pc = nxt;
      end
      if (!m_miss) begin
        if (!mh) begin
          m_miss = 1;
          m_req = pc0 - pc0 % LB;
        end
      end else if (mem_resp_valid) begin
        ix = int'((m_req / LB) % CL);
        mvld[ix] = 1;
        mtag[ix] = m_req / (LB * CL);
        m_miss = 0;
      end
    end
    popped = 0;
  end

  // Monitor
  always begin
    @(negedge clk);
    chk("inst_valid", 32'(inst_valid), 32'(expq.size() != 0));
    chk("req_valid", 32'(mem_req_valid), 32'(m_miss));
    if (m_miss) chk("req_addr", mem_req_addr, m_req);
    if (expq.size() != 0) begin
      if (inst_valid) begin
        chk("head_pc", inst_pc, expq[0].pc);
        chk("head_inst", inst, expq[0].inst);
        chk("head_pred", 32'(inst_pred_taken), 32'(expq[0].pred));
      end
      if (dec_ready && rdy && !redirect_valid && !rst) begin
        void'(expq.pop_front());
        popped = 1;
      end
    end
  end

  // Memory responder, plus stray pulses while no request is open
  int lat = 2;
  always begin
    @(posedge clk);
    #1;
    mem_resp_valid = 1'b0;
    if (mem_req_valid === 1'b1) begin
      if (lat == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data = line_of(mem_req_addr);
        lat = $urandom_range(0, 4);
      end else lat--;
    end else if (img_mode == 2 && $urandom_range(0, 19) == 0) begin
      mem_resp_valid = 1'b1;
      mem_resp_data = {16{$urandom}};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    bp_upd_valid = 1'b0;
  endtask

  task automatic reset_dut(input int mode);
    rst = 1'b1;
    img_mode = mode;
    dec_ready = 1'b0;
    rdy = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic at_negedge();
    @(negedge clk);
  endtask

  task automatic resync();
    @(posedge clk);
    #1;
  endtask

  bit found;

  initial begin
    rst = 1'b1; rdy = 1'b1; dec_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    bp_upd_valid = 1'b0; bp_upd_pc = '0; bp_upd_taken = 1'b0;

    // Cold start on a NOP image
    reset_dut(0);
    step();
    at_negedge();
    chk("cold_req_valid", 32'(mem_req_valid), 32'd1);
    chk("cold_req_addr", mem_req_addr, 32'h0);
    resync();
    repeat (20) step();
    at_negedge();
    chk("full_valid", 32'(inst_valid), 32'd1);
    chk("full_head_pc", inst_pc, 32'h0);
    resync();
    dec_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = mem_req_valid && mem_req_addr == 32'h40;
    end
    chk("miss_0x40", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    step();
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      found = mem_req_valid && mem_req_addr == 32'h400;
    end
    chk("req_0x400", 32'(found), 32'd1);
    repeat (20) step();

    // JAL / branch image
    reset_dut(1);
    dec_ready = 1'b1;
    repeat (30) step();
    for (int i = 0; i < 2; i++) begin
      bp_upd_valid = 1'b1; bp_upd_pc = 32'h10; bp_upd_taken = 1'b1;
      step();
    end
    dec_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    repeat (15) step();
    at_negedge();
    chk("br_taken_pc", inst_pc, 32'h10);
    chk("br_taken_pred", 32'(inst_pred_taken), 32'd1);
    resync();
    dec_ready = 1'b1;
    repeat (10) step();
    for (int i = 0; i < 3; i++) begin
      bp_upd_valid = 1'b1; bp_upd_pc = 32'h10; bp_upd_taken = 1'b0;
      step();
    end
    dec_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    repeat (15) step();
    at_negedge();
    chk("br_nt_pc", inst_pc, 32'h10);
    chk("br_nt_pred", 32'(inst_pred_taken), 32'd0);
    resync();
    repeat (10) step();
    dec_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    dec_ready = 1'b0;
    at_negedge();
    chk("flush_valid", 32'(inst_valid), 32'd0);
    resync();
    dec_ready = 1'b1;
    repeat (30) step();

    // Randomized traffic
    reset_dut(2);
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(0, 9) != 0);
      dec_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 39) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'($urandom_range(0, 1023)) * 32'd4;
      end
      if ($urandom_range(0, 4) == 0) begin
        bp_upd_valid = 1'b1;
        bp_upd_pc = 32'($urandom_range(0, 1023)) * 32'd4;
        bp_upd_taken = $urandom_range(0, 1) == 1;
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
      rst = 1'b0;
    end
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
